// File: rtl/l1_cache_2way_pkg.sv
// Shared constants, types and address-field helpers for the two-way L1 cache.
package cache_types;
    localparam int S_OFFSET = 4;
    localparam int S_INDEX  = 3;
    localparam int S_TAG    = 16 - S_INDEX - S_OFFSET;
    localparam int S_LINE   = 128;
    localparam int S_SETS   = 1 << S_INDEX;
    localparam int S_WORDW  = S_OFFSET - 1;

    typedef logic [S_TAG-1:0]   tag_t;
    typedef logic [S_INDEX-1:0] index_t;
    typedef logic [S_LINE-1:0]  line_t;
    typedef logic [S_WORDW-1:0] word_t;

    typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_t;

    function automatic tag_t addr_tag(input logic [15:0] addr);
        return addr[15:S_INDEX+S_OFFSET];
    endfunction

    function automatic index_t addr_index(input logic [15:0] addr);
        return addr[S_INDEX+S_OFFSET-1:S_OFFSET];
    endfunction

    function automatic word_t addr_word(input logic [15:0] addr);
        return addr[S_OFFSET-1:1];
    endfunction
endpackage

// File: rtl/cache_way.sv
// One way of the cache: per-set data, tag, valid and dirty storage.
// Reads are combinational; writes land on the rising edge.
module cache_way
    import cache_types::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [S_INDEX-1:0] index_i,
    input  logic               data_we_i,
    input  logic [S_LINE-1:0]  data_i,
    input  logic               tag_we_i,
    input  logic [S_TAG-1:0]   tag_i,
    input  logic               valid_we_i,
    input  logic               valid_i,
    input  logic               dirty_we_i,
    input  logic               dirty_i,
    output logic [S_LINE-1:0]  data_o,
    output logic [S_TAG-1:0]   tag_o,
    output logic               valid_o,
    output logic               dirty_o
);
    line_t             data_q [S_SETS];
    tag_t              tag_q  [S_SETS];
    logic [S_SETS-1:0] valid_q;
    logic [S_SETS-1:0] dirty_q;

    // Payload arrays carry no reset; valid gates their use.
    always_ff @(posedge clk) begin
        if (data_we_i) data_q[index_i] <= data_i;
        if (tag_we_i)  tag_q[index_i]  <= tag_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (valid_we_i) valid_q[index_i] <= valid_i;
            if (dirty_we_i) dirty_q[index_i] <= dirty_i;
        end
    end

    assign data_o  = data_q[index_i];
    assign tag_o   = tag_q[index_i];
    assign valid_o = valid_q[index_i];
    assign dirty_o = dirty_q[index_i];
endmodule

// File: rtl/l1_cache_2way.sv
// Two-way set-associative write-back/write-allocate L1 cache: FSM, hit logic,
// LRU victim tracking, write merge and physical-memory drive.
module l1_cache_2way
    import cache_types::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [15:0]  mem_address,
    input  logic [15:0]  mem_wdata,
    input  logic [1:0]   mem_byte_enable,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);
    state_t            state_q, state_d;
    logic [S_SETS-1:0] lru_q, lru_d;
    logic              victim_q, victim_d;
    index_t            victim_index_q, victim_index_d;

    tag_t   req_tag;
    index_t req_index;
    word_t  req_word;
    index_t way_index;
    logic   unused_addr_bit;

    logic [S_LINE-1:0] way_data [2];
    logic [S_TAG-1:0]  way_tag  [2];
    logic [1:0]        way_valid;
    logic [1:0]        way_dirty;
    logic [1:0]        data_we, tag_we, valid_we, dirty_we;
    logic [S_LINE-1:0] wline;
    logic              dirty_val;

    logic [1:0]        hit;
    logic              hit_way;
    logic [S_LINE-1:0] hit_line, merged_line;
    logic [15:0]       hit_word, merged_word;
    logic              miss_way, miss_dirty;

    assign req_tag         = addr_tag(mem_address);
    assign req_index       = addr_index(mem_address);
    assign req_word        = addr_word(mem_address);
    assign unused_addr_bit = mem_address[0];
    assign way_index       = (state_q == COMPARE) ? req_index : victim_index_q;

    for (genvar g = 0; g < 2; g++) begin : g_way
        cache_way u_way (
            .clk        (clk),
            .rst_n      (rst_n),
            .index_i    (way_index),
            .data_we_i  (data_we[g]),
            .data_i     (wline),
            .tag_we_i   (tag_we[g]),
            .tag_i      (req_tag),
            .valid_we_i (valid_we[g]),
            .valid_i    (1'b1),
            .dirty_we_i (dirty_we[g]),
            .dirty_i    (dirty_val),
            .data_o     (way_data[g]),
            .tag_o      (way_tag[g]),
            .valid_o    (way_valid[g]),
            .dirty_o    (way_dirty[g])
        );
        assign hit[g] = way_valid[g] && (way_tag[g] == req_tag);
    end

    assign hit_way   = hit[1];
    assign hit_line  = way_data[hit_way];
    assign hit_word  = hit_line[{req_word, 4'b0} +: 16];
    assign mem_rdata = hit_word;

    // Prefer an empty way; only a full set consults LRU.
    assign miss_way   = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_q[req_index]);
    assign miss_dirty = way_valid[miss_way] && way_dirty[miss_way];
    assign pmem_wdata = way_data[victim_q];

    always_comb begin
        merged_word = hit_word;
        if (mem_byte_enable[0]) merged_word[7:0]  = mem_wdata[7:0];
        if (mem_byte_enable[1]) merged_word[15:8] = mem_wdata[15:8];
        merged_line = hit_line;
        merged_line[{req_word, 4'b0} +: 16] = merged_word;
    end

    always_comb begin
        state_d        = state_q;
        lru_d          = lru_q;
        victim_d       = victim_q;
        victim_index_d = victim_index_q;
        mem_resp       = 1'b0;
        pmem_read      = 1'b0;
        pmem_write     = 1'b0;
        pmem_address   = '0;
        data_we        = '0;
        tag_we         = '0;
        valid_we       = '0;
        dirty_we       = '0;
        wline          = pmem_rdata;
        dirty_val      = 1'b0;
        unique case (state_q)
            COMPARE: begin
                if (mem_read || mem_write) begin
                    if (|hit) begin
                        mem_resp         = 1'b1;
                        lru_d[req_index] = ~hit_way;
                        if (mem_write) begin
                            data_we[hit_way]  = 1'b1;
                            dirty_we[hit_way] = 1'b1;
                            wline             = merged_line;
                            dirty_val         = 1'b1;
                        end
                    end else begin
                        victim_d       = miss_way;
                        victim_index_d = req_index;
                        state_d        = miss_dirty ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {way_tag[victim_q], victim_index_q, {S_OFFSET{1'b0}}};
                if (pmem_resp) begin
                    dirty_we[victim_q] = 1'b1;
                    state_d            = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {req_tag, victim_index_q, {S_OFFSET{1'b0}}};
                if (pmem_resp) begin
                    data_we[victim_q]  = 1'b1;
                    tag_we[victim_q]   = 1'b1;
                    valid_we[victim_q] = 1'b1;
                    dirty_we[victim_q] = 1'b1;
                    state_d            = COMPARE;
                end
            end
            default: state_d = COMPARE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= COMPARE;
            lru_q          <= '0;
            victim_q       <= 1'b0;
            victim_index_q <= '0;
        end else begin
            state_q        <= state_d;
            lru_q          <= lru_d;
            victim_q       <= victim_d;
            victim_index_q <= victim_index_d;
        end
    end
endmodule

// File: tb/tb_l1_cache_2way.sv
// Self-checking bench for l1_cache_2way: transaction-level cache model plus a
// latency-programmable physical memory responder.
module tb_l1_cache_2way;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         mem_read, mem_write;
    logic [15:0]  mem_address, mem_wdata;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic         pmem_read, pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;

    always #5 clk = ~clk;

    l1_cache_2way dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    int errors = 0;
    int checks = 0;
    int lat    = 1;
    bit chk_en = 1'b0;

    logic [127:0] pmem   [4096];
    logic [127:0] refmem [4096];

    // Model: per set, two slots with tag/valid/dirty/data and the way to evict next.
    logic [8:0]   m_tag   [8][2];
    bit           m_val   [8][2];
    bit           m_dirty [8][2];
    logic [127:0] m_data  [8][2];
    bit           m_lru   [8];

    bit           exp_wb, exp_fill, exp_rd;
    logic [15:0]  exp_wb_addr, exp_fill_addr, exp_rdata;
    logic [127:0] exp_wb_data;
    int           exp_lat;

    logic [15:0]  seen_wb_addr, seen_fill_addr, got_rdata;
    logic [127:0] seen_wb_data;
    int           got_lat;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 8; s++) begin
            m_lru[s] = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_val[s][k]   = 1'b0;
                m_dirty[s][k] = 1'b0;
            end
        end
    endtask

    task automatic model_req(input bit wr, input logic [15:0] a, input logic [15:0] wd, input logic [1:0] be);
        logic [8:0]  t;
        logic [15:0] word;
        int s, w, h, v;
        t = a[15:7];
        s = int'(a[6:4]);
        w = int'(a[3:1]);
        h = -1;
        exp_wb   = 1'b0;
        exp_fill = 1'b0;
        for (int k = 0; k < 2; k++)
            if (m_val[s][k] && m_tag[s][k] == t) h = k;
        if (h < 0) begin
            v = !m_val[s][0] ? 0 : (!m_val[s][1] ? 1 : int'(m_lru[s]));
            if (m_val[s][v] && m_dirty[s][v]) begin
                exp_wb      = 1'b1;
                exp_wb_addr = {m_tag[s][v], 3'(s), 4'b0};
                exp_wb_data = m_data[s][v];
                refmem[{m_tag[s][v], 3'(s)}] = m_data[s][v];
            end
            exp_fill      = 1'b1;
            exp_fill_addr = {t, 3'(s), 4'b0};
            m_data[s][v]  = refmem[{t, 3'(s)}];
            m_tag[s][v]   = t;
            m_val[s][v]   = 1'b1;
            m_dirty[s][v] = 1'b0;
            h = v;
            exp_lat = 1 + (exp_wb ? lat : 0) + lat;
        end else begin
            exp_lat = 0;
        end
        word      = m_data[s][h][w*16 +: 16];
        exp_rd    = !wr;
        exp_rdata = word;
        if (wr) begin
            if (be[0]) word[7:0]  = wd[7:0];
            if (be[1]) word[15:8] = wd[15:8];
            m_data[s][h][w*16 +: 16] = word;
            m_dirty[s][h] = 1'b1;
        end
        m_lru[s] = (h == 0);
    endtask

    // Called just after a rising edge; returns just after the edge that retires the request.
    task automatic do_req(input bit rd, input bit wr, input logic [15:0] a,
                          input logic [15:0] wd, input logic [1:0] be, input int l);
        lat = l;
        model_req(wr, a, wd, be);
        mem_read        = rd;
        mem_write       = wr;
        mem_address     = a;
        mem_wdata       = wd;
        mem_byte_enable = be;
        got_lat = -1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (mem_resp) begin
                got_lat   = n;
                got_rdata = mem_rdata;
                break;
            end
        end
        check("latency", 128'(got_lat), 128'(exp_lat));
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // Physical memory: answers after `lat` cycles of a held request, one-cycle resp.
    initial begin
        int cnt;
        cnt        = 0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            pmem_resp = 1'b0;
            if (!rst_n) begin
                cnt = 0;
            end else if (pmem_read || pmem_write) begin
                cnt++;
                if (cnt >= lat) begin
                    cnt       = 0;
                    pmem_resp = 1'b1;
                    if (pmem_write) pmem[pmem_address[15:4]] = pmem_wdata;
                    else            pmem_rdata = pmem[pmem_address[15:4]];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("pmem_rw_overlap", 128'(pmem_read && pmem_write), 128'(0));
            if (pmem_write) begin
                check("wb_expected", 128'(exp_wb), 128'(1));
                check("wb_addr", 128'(pmem_address), 128'(exp_wb_addr));
                check("wb_data", pmem_wdata, exp_wb_data);
                seen_wb_addr = pmem_address;
                seen_wb_data = pmem_wdata;
            end
            if (pmem_read) begin
                check("fill_expected", 128'(exp_fill), 128'(1));
                check("fill_addr", 128'(pmem_address), 128'(exp_fill_addr));
                seen_fill_addr = pmem_address;
            end
            if (mem_resp && exp_rd)
                check("rdata", 128'(mem_rdata), 128'(exp_rdata));
        end
    end

    initial begin
        logic [127:0] ln;
        logic [15:0]  a;
        int           r, l;
        for (int L = 0; L < 4096; L++) begin
            for (int w = 0; w < 8; w++)
                ln[w*16 +: 16] = 16'(32'h1000 + L * 32'h44 + w);
            pmem[L]   = ln;
            refmem[L] = ln;
        end
        model_reset();
        exp_wb = 1'b0; exp_fill = 1'b0; exp_rd = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0;
        mem_address = '0; mem_wdata = '0; mem_byte_enable = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("reset_mem_resp", 128'(mem_resp), 128'(0));
        check("reset_pmem_read", 128'(pmem_read), 128'(0));
        check("reset_pmem_write", 128'(pmem_write), 128'(0));
        check("reset_pmem_address", 128'(pmem_address), 128'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        // Cold read then immediate re-read.
        do_req(1, 0, 16'h0042, 16'h0, 2'b00, 2);
        check("cold_rdata", 128'(got_rdata), 128'(16'h1111));
        check("cold_fill_addr", 128'(seen_fill_addr), 128'(16'h0040));
        check("cold_latency", 128'(got_lat), 128'(3));
        do_req(1, 0, 16'h0042, 16'h0, 2'b00, 2);
        check("reread_latency", 128'(got_lat), 128'(0));

        // Low-byte write hit.
        do_req(0, 1, 16'h0042, 16'hABCD, 2'b01, 2);
        check("write_hit_latency", 128'(got_lat), 128'(0));
        do_req(1, 0, 16'h0042, 16'h0, 2'b00, 2);
        check("byte_merge", 128'(got_rdata), 128'(16'h11CD));

        // Two-way fill and LRU in set 4.
        do_req(1, 0, 16'h00C0, 16'h0, 2'b00, 2);
        do_req(1, 0, 16'h0040, 16'h0, 2'b00, 2);
        do_req(1, 0, 16'h0140, 16'h0, 2'b00, 2);
        check("lru_clean_miss", 128'(got_lat), 128'(3));
        do_req(1, 0, 16'h0040, 16'h0, 2'b00, 2);
        check("lru_kept_mru", 128'(got_lat), 128'(0));
        do_req(1, 0, 16'h00C0, 16'h0, 2'b00, 2);
        check("lru_evicted_c0", 128'(got_lat), 128'(3));

        // Dirty eviction of 0x0040 with a slow memory.
        do_req(1, 0, 16'h00C0, 16'h0, 2'b00, 10);
        do_req(1, 0, 16'h0140, 16'h0, 2'b00, 10);
        check("dirty_latency", 128'(got_lat), 128'(21));
        check("dirty_wb_addr", 128'(seen_wb_addr), 128'(16'h0040));
        check("dirty_wb_word1", 128'(seen_wb_data[31:16]), 128'(16'h11CD));
        check("dirty_fill_addr", 128'(seen_fill_addr), 128'(16'h0140));

        // Reset in the middle of a line fill.
        lat = 10;
        exp_wb = 1'b0; exp_fill = 1'b1; exp_fill_addr = 16'h0800; exp_rd = 1'b0;
        mem_read = 1'b1; mem_address = 16'h0800;
        r = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (pmem_read) begin r = 1; break; end
        end
        check("rst_fill_started", 128'(r), 128'(1));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_pmem_read", 128'(pmem_read), 128'(0));
        check("rst_mem_resp", 128'(mem_resp), 128'(0));
        mem_read = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        do_req(1, 0, 16'h0800, 16'h0, 2'b00, 3);
        check("rst_refill_latency", 128'(got_lat), 128'(4));
        check("rst_refill_rdata", 128'(got_rdata), 128'(16'h3200));

        // Randomized traffic over four tags with mixed latencies.
        for (int i = 0; i < 300; i++) begin
            a = 16'(($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4) | ($urandom_range(0, 7) << 1));
            case ($urandom_range(0, 2))
                0:       l = 1;
                1:       l = 10;
                default: l = int'($urandom_range(2, 5));
            endcase
            r = int'($urandom_range(0, 7));
            do_req(r <= 3 || r == 7, r >= 4, a, 16'($urandom), 2'($urandom_range(0, 3)), l);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
